// File: rtl/half_adder.sv
// half_adder: WIDTH independent half-adder lanes behind a registered output
// stage with a one-entry skid buffer. Each result leaves the block one cycle
// after it was accepted.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The producer holds in_valid/a/b until in_ready accepts them. The
// block holds out_valid/sum/carry stable until out_ready accepts them.
// in_ready is decoded from the occupancy state alone, so it never depends
// combinationally on out_ready.
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  input  logic             out_ready
);

  // Occupancy of the output register and skid buffer.
  // ST_RESET : first cycle after reset release, nothing is accepted yet
  // ST_EMPTY : output register and skid buffer both empty
  // ST_ONE   : output register holds a result, skid buffer empty
  // ST_TWO   : output register and skid buffer both hold results
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_EMPTY = 2'd1,
    ST_ONE   = 2'd2,
    ST_TWO   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic             load_out;
  logic             load_skid;
  logic             skid_to_out;

  logic [WIDTH-1:0] new_sum;
  logic [WIDTH-1:0] new_carry;

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic [WIDTH-1:0] skid_sum_q;
  logic [WIDTH-1:0] skid_carry_q;

  // Lanes are fully independent: no carry ripples between bit positions.
  assign new_sum   = a ^ b;
  assign new_carry = a & b;

  assign sum   = sum_q;
  assign carry = carry_q;

  // Occupancy state register; reset parks the block in ST_RESET.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, handshake outputs and datapath load strobes.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_EMPTY;
      end
      ST_EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_out = 1'b1;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        case ({in_valid, out_ready})
          2'b10: begin
            // Consumer stalled: park the new result, keep outputs stable.
            load_skid = 1'b1;
            state_d   = ST_TWO;
          end
          2'b11: begin
            // Old result leaves while the new one replaces it.
            load_out = 1'b1;
            state_d  = ST_ONE;
          end
          2'b01: begin
            state_d = ST_EMPTY;
          end
          default: begin
            state_d = ST_ONE;
          end
        endcase
      end
      ST_TWO: begin
        out_valid = 1'b1;
        if (out_ready) begin
          skid_to_out = 1'b1;
          state_d     = ST_ONE;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // Output register: loaded from the lanes or refilled from the skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else if (load_out) begin
      sum_q   <= new_sum;
      carry_q <= new_carry;
    end else if (skid_to_out) begin
      sum_q   <= skid_sum_q;
      carry_q <= skid_carry_q;
    end
  end

  // Skid buffer: captures a result accepted while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_sum_q   <= '0;
      skid_carry_q <= '0;
    end else if (load_skid) begin
      skid_sum_q   <= new_sum;
      skid_carry_q <= new_carry;
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed vectors into an 8-lane and a 1-lane half_adder that
// share clock, reset and handshakes; a queue-based scoreboard checks results.
module tb_half_adder;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_w;
  logic [7:0] sum_w;
  logic [7:0] carry_w;
  logic       out_valid_w;

  logic       a_n;
  logic       b_n;
  logic       in_ready_n;
  logic       sum_n;
  logic       carry_n;
  logic       out_valid_n;

  logic       toggle_mode;

  int checks;
  int errors;

  logic [15:0] exp_w_q[$];
  logic [1:0]  exp_n_q[$];

  // Hand-computed vectors: sum = a ^ b, carry = a & b per lane.
  logic [7:0] vec_a[10] = '{8'h00, 8'h00, 8'hA5, 8'hFF, 8'hF0, 8'hFF, 8'h0F, 8'h33, 8'hC3, 8'h6E};
  logic [7:0] vec_b[10] = '{8'h00, 8'h01, 8'h5A, 8'h01, 8'h3C, 8'hFF, 8'h0E, 8'h55, 8'h81, 8'hB7};
  logic [7:0] vec_s[10] = '{8'h00, 8'h01, 8'hFF, 8'hFE, 8'hCC, 8'h00, 8'h01, 8'h66, 8'h42, 8'hD9};
  logic [7:0] vec_c[10] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h30, 8'hFF, 8'h0E, 8'h11, 8'h81, 8'h26};

  assign a_n = a[0];
  assign b_n = b[0];

  half_adder #(.WIDTH(8)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .sum       (sum_w),
    .carry     (carry_w),
    .out_valid (out_valid_w),
    .out_ready (out_ready)
  );

  half_adder #(.WIDTH(1)) dut_n (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a_n),
    .b         (b_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_n),
    .sum       (sum_n),
    .carry     (carry_n),
    .out_valid (out_valid_n),
    .out_ready (out_ready)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives out_ready alternately while toggle_mode is set.
  always begin
    @(negedge clk);
    #1;
    if (toggle_mode) out_ready = ~out_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offers vector idx until accepted; expected results enter the scoreboard
  // on the acceptance cycle. Called at negedge+1, returns at negedge+1.
  task automatic send(input int idx);
    bit done;
    done     = 1'b0;
    a        = vec_a[idx];
    b        = vec_b[idx];
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (in_ready_w) begin
        exp_w_q.push_back({vec_s[idx], vec_c[idx]});
        exp_n_q.push_back({vec_s[idx][0], vec_c[idx][0]});
        done = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    in_valid = 1'b0;
    a        = ~vec_a[idx];
    b        = ~vec_b[idx];
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: vector %0d in_ready stayed 0, expected 1", idx);
    end else begin
      chk("latency_out_valid_w", 32'(out_valid_w), 32'd1);
      chk("latency_out_valid_n", 32'(out_valid_n), 32'd1);
    end
  endtask

  // Waits (bounded) for the scoreboard to empty.
  task automatic drain();
    for (int i = 0; i < 100 && (exp_w_q.size() != 0 || exp_n_q.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_w", 32'(exp_w_q.size()), 32'd0);
    chk("drain_n", 32'(exp_n_q.size()), 32'd0);
  endtask

  // Monitor: samples at negedge+2 the values that apply at the next rising
  // edge; pops on output transfers and checks stability while stalled.
  initial begin
    logic        hold_w;
    logic        hold_n;
    logic [15:0] held_w;
    logic [1:0]  held_n;
    logic [15:0] e_w;
    logic [1:0]  e_n;
    hold_w = 1'b0;
    hold_n = 1'b0;
    held_w = '0;
    held_n = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold_w = 1'b0;
        hold_n = 1'b0;
      end else begin
        if (hold_w) begin
          chk("stall_valid_w", 32'(out_valid_w), 32'd1);
          chk("stall_data_w", 32'({sum_w, carry_w}), 32'(held_w));
        end
        if (hold_n) begin
          chk("stall_valid_n", 32'(out_valid_n), 32'd1);
          chk("stall_data_n", 32'({sum_n, carry_n}), 32'(held_n));
        end
        if (out_valid_w && out_ready) begin
          if (exp_w_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_w: got %0h, expected no output", {sum_w, carry_w});
          end else begin
            e_w = exp_w_q.pop_front();
            chk("result_w", 32'({sum_w, carry_w}), 32'(e_w));
          end
        end
        if (out_valid_n && out_ready) begin
          if (exp_n_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_n: got %0h, expected no output", {sum_n, carry_n});
          end else begin
            e_n = exp_n_q.pop_front();
            chk("result_n", 32'({sum_n, carry_n}), 32'(e_n));
          end
        end
        hold_w = out_valid_w && !out_ready;
        hold_n = out_valid_n && !out_ready;
        held_w = {sum_w, carry_w};
        held_n = {sum_n, carry_n};
      end
    end
  end

  // Directed sequence.
  initial begin
    checks      = 0;
    errors      = 0;
    toggle_mode = 1'b0;
    rst_n       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    #1 rst_n = 1'b0;

    // Reset values, then release with a request pending: first edge takes nothing.
    @(negedge clk);
    #1;
    chk("rst_out_valid_w", 32'(out_valid_w), 32'd0);
    chk("rst_sum_w", 32'(sum_w), 32'd0);
    chk("rst_carry_w", 32'(carry_w), 32'd0);
    chk("rst_in_ready_w", 32'(in_ready_w), 32'd0);
    chk("rst_out_valid_n", 32'(out_valid_n), 32'd0);
    chk("rst_in_ready_n", 32'(in_ready_n), 32'd0);
    a        = 8'hFF;
    b        = 8'hFF;
    in_valid = 1'b1;
    #2 rst_n = 1'b1;
    chk("release_in_ready_low", 32'(in_ready_w), 32'd0);
    @(negedge clk);
    #1;
    chk("release_in_ready_w", 32'(in_ready_w), 32'd1);
    chk("release_in_ready_n", 32'(in_ready_n), 32'd1);
    chk("release_no_output_w", 32'(out_valid_w), 32'd0);
    chk("release_no_output_n", 32'(out_valid_n), 32'd0);
    in_valid = 1'b0;

    // Truth table on lane 0 (and wide patterns), consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(i);
    @(negedge clk);
    #1;

    // Single result: valid for exactly one cycle.
    send(4);
    chk("single_sum_w", 32'(sum_w), 32'h0CC);
    chk("single_carry_w", 32'(carry_w), 32'h030);
    @(negedge clk);
    #1;
    chk("single_valid_drop_w", 32'(out_valid_w), 32'd0);
    chk("single_valid_drop_n", 32'(out_valid_n), 32'd0);

    // Back-to-back with consumer stalled: output holds, skid fills, third blocked.
    out_ready = 1'b0;
    send(5);
    send(6);
    chk("stall_in_ready_w", 32'(in_ready_w), 32'd0);
    chk("stall_in_ready_n", 32'(in_ready_n), 32'd0);
    chk("stall_first_sum_w", 32'(sum_w), 32'h000);
    chk("stall_first_carry_w", 32'(carry_w), 32'h0FF);
    a        = vec_a[7];
    b        = vec_b[7];
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("third_blocked", 32'(in_ready_w), 32'd0);
      @(negedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("skid_moved_sum_w", 32'(sum_w), 32'h001);
    chk("skid_freed_in_ready", 32'(in_ready_w), 32'd1);
    drain();

    // Streaming with out_ready toggling every cycle.
    toggle_mode = 1'b1;
    for (int i = 7; i < 10; i++) send(i);
    for (int i = 0; i < 7; i++) send(i);
    drain();
    toggle_mode = 1'b0;
    @(negedge clk);
    #1;

    // Asynchronous reset with output valid and skid full.
    out_ready = 1'b0;
    send(1);
    send(2);
    chk("pre_reset_full", 32'(in_ready_w), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid_w", 32'(out_valid_w), 32'd0);
    chk("async_sum_w", 32'(sum_w), 32'd0);
    chk("async_carry_w", 32'(carry_w), 32'd0);
    chk("async_in_ready_w", 32'(in_ready_w), 32'd0);
    chk("async_out_valid_n", 32'(out_valid_n), 32'd0);
    chk("async_in_ready_n", 32'(in_ready_n), 32'd0);
    exp_w_q.delete();
    exp_n_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rerelease_in_ready_low", 32'(in_ready_w), 32'd0);
    @(negedge clk);
    #1;
    chk("rerelease_in_ready_w", 32'(in_ready_w), 32'd1);
    chk("rerelease_no_stale_w", 32'(out_valid_w), 32'd0);
    chk("rerelease_no_stale_n", 32'(out_valid_n), 32'd0);
    send(9);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH SHALL have default 1 and set the number of independent bit lanes (legal range 1..64).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 Port a  input  WIDTH  SHALL be addend A, one bit per lane.
REQ-005 Port b  input  WIDTH  SHALL be addend B, one bit per lane.
REQ-006 Port in_valid  input  1  SHALL qualify a and b as a transfer request.
REQ-007 Port in_ready  output  1  SHALL indicate the block can accept a transfer this cycle.
REQ-008 Port sum  output  WIDTH  SHALL be the registered per-lane sum bits.
REQ-009 Port carry  output  WIDTH  SHALL be the registered per-lane carry bits.
REQ-010 Port out_valid  output  1  SHALL qualify sum and carry.
REQ-011 Port out_ready  input  1  SHALL indicate the consumer accepts sum and carry this cycle.

Function
REQ-012 Per lane i, the result SHALL be sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i]; lanes SHALL NOT interact (no carry propagation between lanes).
REQ-013 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-014 Latency SHALL be exactly 1 cycle: the result of an input transfer appears on sum/carry with out_valid=1 after the same edge.
REQ-015 The output stage SHALL be a single register plus a one-entry skid buffer, so in_ready SHALL depend only on internal state (no combinational path from out_ready to in_ready).
REQ-016 in_ready SHALL be 1 whenever the skid buffer is empty and 0 whenever it is full.
REQ-017 If out_valid=1 and out_ready=0 at an edge with an input transfer, the new result SHALL go into the skid buffer and sum/carry/out_valid SHALL hold unchanged.
REQ-018 While out_valid=1 and out_ready=0, sum, carry and out_valid SHALL remain stable.
REQ-019 On an output transfer with the skid buffer full, the skid contents SHALL move to the output register and the skid SHALL become empty on the same edge.
REQ-020 On an output transfer with the skid empty and a simultaneous input transfer, the new result SHALL replace the output register, and out_valid SHALL stay 1.
REQ-021 On an output transfer with the skid empty and no input transfer, out_valid SHALL drop to 0.
REQ-022 Results SHALL leave the block in input-transfer order; none SHALL be dropped or duplicated.
REQ-023 When out_valid=0, sum and carry SHALL hold their last value; consumers SHALL ignore them.
REQ-024 Inputs a and b SHALL be sampled only on an input transfer; changes at other times SHALL have no effect.

Reset
REQ-025 While rst_n=0, regardless of clk: out_valid=0, sum=0, carry=0, skid buffer empty, in_ready=0.
REQ-026 On the first rising clk edge after rst_n deasserts, in_ready SHALL become 1; no transfer SHALL be accepted on that edge.
REQ-027 Reset asserted mid-operation SHALL immediately discard the output register and skid contents without emitting them.

Verification
REQ-028 WIDTH=1, out_ready=1, apply (a,b) = (0,0),(0,1),(1,0),(1,1), one per transfer -> (sum,carry) = (0,0),(1,0),(1,0),(0,1), each one cycle later.
REQ-029 WIDTH=8, a=0xF0, b=0x3C, out_ready=1 -> sum=0xCC, carry=0x30 after 1 cycle, out_valid=1 for exactly one cycle.
REQ-030 Back-to-back transfers with out_ready=0 -> first result held on outputs, second in skid, in_ready=0, third request not accepted; raise out_ready -> results emerge in order, one per cycle.
REQ-031 Streaming with out_ready toggling every cycle -> all results in order, no drops or duplicates, sum/carry stable while stalled.
REQ-032 Assert rst_n=0 asynchronously between edges with out_valid=1 and skid full -> out_valid, sum, carry and in_ready go to 0 immediately; the first edge after release gives in_ready=1 and no stale output.
